// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM pipeline stage: bus widths, payload layouts and stall decoding.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 71;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_ADDR_WD      = 10;

    localparam logic [1:0] STALL_RUN   = 2'b00;
    localparam logic [1:0] STALL_HOLD  = 2'b01;
    localparam logic [1:0] STALL_FLUSH = 2'b10;

    typedef enum logic [1:0] {
        STALL_MODE_RUN   = 2'b00,
        STALL_MODE_HOLD  = 2'b01,
        STALL_MODE_FLUSH = 2'b10
    } stall_mode_e;

    typedef struct packed {
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    // A simultaneous flush+hold request (2'b11) cannot be honoured, so it degrades to hold.
    function automatic stall_mode_e decode_stall(input logic [1:0] stall);
        stall_mode_e mode_s;
        case (stall)
            STALL_RUN:   mode_s = STALL_MODE_RUN;
            STALL_FLUSH: mode_s = STALL_MODE_FLUSH;
            STALL_HOLD:  mode_s = STALL_MODE_HOLD;
            default:     mode_s = STALL_MODE_HOLD;
        endcase
        return mode_s;
    endfunction

endpackage

// File: rtl/mem_stage_if.sv
// EX->MEM and MEM->WB handshake bundle; the stage itself takes the slave view.
interface mem_stage_if;
    import mem_stage_pkg::*;

    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic [MS_ADDR_WD-1:0]      es_to_ms_addr;
    logic                       ms_allowin;
    logic                       ms_to_ws_valid;
    logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus;
    logic [MS_ADDR_WD-1:0]      ms_to_ws_addr;
    logic                       ws_allowin;

    modport slave (
        input  es_to_ms_valid,
        input  es_to_ms_bus,
        input  es_to_ms_addr,
        input  ws_allowin,
        output ms_allowin,
        output ms_to_ws_valid,
        output ms_to_ws_bus,
        output ms_to_ws_addr
    );

    modport master (
        output es_to_ms_valid,
        output es_to_ms_bus,
        output es_to_ms_addr,
        output ws_allowin,
        input  ms_allowin,
        input  ms_to_ws_valid,
        input  ms_to_ws_bus,
        input  ms_to_ws_addr
    );

endinterface

// File: rtl/ms_rdata_buf.sv
// One-entry load-data buffer: snapshots the SRAM read data in a load's first MEM cycle when WB
// does not take it, so later SRAM activity cannot corrupt the value handed to WB.
module ms_rdata_buf (
    input  logic        clk,
    input  logic        reset,
    input  logic        entry,
    input  logic        ms_valid,
    input  logic        res_from_mem,
    input  logic        leaving,
    input  logic [31:0] data_sram_rdata,
    output logic [31:0] load_data
);

    logic        first_cyc_r;
    logic        rd_held_r;
    logic [31:0] rd_hold_r;
    logic        capture_s;

    assign capture_s = ms_valid & res_from_mem & first_cyc_r & ~leaving;

    // Track the first MEM cycle and whether the buffer owns valid data for the current load.
    always_ff @(posedge clk) begin
        if (reset) begin
            first_cyc_r <= 1'b0;
            rd_held_r   <= 1'b0;
        end else begin
            first_cyc_r <= entry;
            if (entry) begin
                rd_held_r <= 1'b0;
            end else if (capture_s) begin
                rd_held_r <= 1'b1;
            end
        end
    end

    // Data register needs no reset: it is only observed while rd_held_r is set.
    always_ff @(posedge clk) begin
        if (capture_s && !entry) begin
            rd_hold_r <= data_sram_rdata;
        end
    end

    // A load that leaves in its first cycle sees the live SRAM data.
    always_comb begin
        load_data = data_sram_rdata;
        if (rd_held_r) begin
            load_data = rd_hold_r;
        end else begin
            load_data = data_sram_rdata;
        end
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: registers EX results, merges load data, feeds WB, forwarding and hazard logic.
// Optional build macro MEM_STAGE_PERF_EN adds perf_load_cnt / perf_stall_cnt outputs.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    mem_stage_if.slave            pipe,
    input  logic [31:0]           data_sram_rdata,
    input  logic [1:0]            stallM,
    output logic [31:0]           ms_forward_data,
    output logic                  ms_valid_tohazard,
    output logic                  ms_gr_we_tohazard,
    output logic [4:0]            ms_dest_tohazard,
    output logic                  ms_load_tohazard
`ifdef MEM_STAGE_PERF_EN
    ,
    output logic [31:0]           perf_load_cnt,
    output logic [31:0]           perf_stall_cnt
`endif
);

    logic                  ms_valid_r;
    es_to_ms_t             bus_r;
    logic [MS_ADDR_WD-1:0] addr_r;

    stall_mode_e           stall_mode_s;
    logic                  ms_allowin_s;
    logic                  ms_to_ws_valid_s;
    logic                  entry_s;
    logic                  leave_s;
    logic [31:0]           load_data_s;
    logic [31:0]           final_result_s;
    ms_to_ws_t             ws_bus_s;

    assign stall_mode_s = decode_stall(stallM);

    // Handshake: the stage always completes in one cycle, so only stalls and WB gate it.
    always_comb begin
        ms_allowin_s     = 1'b0;
        ms_to_ws_valid_s = 1'b0;
        case (stall_mode_s)
            STALL_MODE_RUN: begin
                ms_allowin_s     = ~ms_valid_r | pipe.ws_allowin;
                ms_to_ws_valid_s = ms_valid_r;
            end
            STALL_MODE_HOLD: begin
                ms_allowin_s     = 1'b0;
                ms_to_ws_valid_s = 1'b0;
            end
            STALL_MODE_FLUSH: begin
                ms_allowin_s     = 1'b1;
                ms_to_ws_valid_s = 1'b0;
            end
            default: begin
                ms_allowin_s     = 1'b0;
                ms_to_ws_valid_s = 1'b0;
            end
        endcase
    end

    assign entry_s = pipe.es_to_ms_valid & ms_allowin_s;
    assign leave_s = ms_to_ws_valid_s & pipe.ws_allowin;

    // Stage occupancy; a flush overwrites the current instruction with whatever EX offers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_r <= 1'b0;
        end else if (ms_allowin_s) begin
            ms_valid_r <= pipe.es_to_ms_valid;
        end
    end

    // Payload capture, deliberately without reset.
    always_ff @(posedge clk) begin
        if (entry_s) begin
            bus_r  <= pipe.es_to_ms_bus;
            addr_r <= pipe.es_to_ms_addr;
        end
    end

    ms_rdata_buf u_rdata_buf (
        .clk             (clk),
        .reset           (reset),
        .entry           (entry_s),
        .ms_valid        (ms_valid_r),
        .res_from_mem    (bus_r.res_from_mem),
        .leaving         (leave_s),
        .data_sram_rdata (data_sram_rdata),
        .load_data       (load_data_s)
    );

    // Result selection and WB payload assembly.
    always_comb begin
        final_result_s        = bus_r.alu_result;
        if (bus_r.res_from_mem) begin
            final_result_s    = load_data_s;
        end else begin
            final_result_s    = bus_r.alu_result;
        end
        ws_bus_s.gr_we        = bus_r.gr_we & ms_valid_r;
        ws_bus_s.dest         = bus_r.dest;
        ws_bus_s.final_result = final_result_s;
        ws_bus_s.pc           = bus_r.pc;
    end

    assign pipe.ms_allowin     = ms_allowin_s;
    assign pipe.ms_to_ws_valid = ms_to_ws_valid_s;
    assign pipe.ms_to_ws_bus   = ws_bus_s;
    assign pipe.ms_to_ws_addr  = addr_r;

    assign ms_forward_data   = final_result_s;
    assign ms_valid_tohazard = ms_valid_r;
    assign ms_gr_we_tohazard = bus_r.gr_we & ms_valid_r;
    assign ms_dest_tohazard  = bus_r.dest;
    assign ms_load_tohazard  = bus_r.res_from_mem & ms_valid_r;

`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_load_cnt_r;
    logic [31:0] perf_stall_cnt_r;

    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_load_cnt_r  <= 32'd0;
            perf_stall_cnt_r <= 32'd0;
        end else begin
            if (leave_s && bus_r.res_from_mem) begin
                perf_load_cnt_r <= perf_load_cnt_r + 32'd1;
            end
            if (ms_valid_r && !pipe.ws_allowin) begin
                perf_stall_cnt_r <= perf_stall_cnt_r + 32'd1;
            end
        end
    end

    assign perf_load_cnt  = perf_load_cnt_r;
    assign perf_stall_cnt = perf_stall_cnt_r;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Directed scoreboard bench for mem_stage: stimulus pushes expected WB beats, a monitor pops them.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] data_sram_rdata;
    logic [1:0]  stallM;
    logic [31:0] ms_forward_data;
    logic        ms_valid_tohazard;
    logic        ms_gr_we_tohazard;
    logic [4:0]  ms_dest_tohazard;
    logic        ms_load_tohazard;
`ifdef MEM_STAGE_PERF_EN
    logic [31:0] perf_load_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    typedef struct packed {
        logic [69:0] bus;
        logic [9:0]  addr;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    mem_stage_if mif ();

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .pipe              (mif),
        .data_sram_rdata   (data_sram_rdata),
        .stallM            (stallM),
        .ms_forward_data   (ms_forward_data),
        .ms_valid_tohazard (ms_valid_tohazard),
        .ms_gr_we_tohazard (ms_gr_we_tohazard),
        .ms_dest_tohazard  (ms_dest_tohazard),
        .ms_load_tohazard  (ms_load_tohazard)
`ifdef MEM_STAGE_PERF_EN
        ,
        .perf_load_cnt     (perf_load_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [70:0] mk_es(input logic res, input logic we, input logic [4:0] dest,
                                          input logic [31:0] alu, input logic [31:0] pc);
        return {res, we, dest, alu, pc};
    endfunction

    function automatic logic [69:0] mk_ws(input logic we, input logic [4:0] dest,
                                          input logic [31:0] fin, input logic [31:0] pc);
        return {we, dest, fin, pc};
    endfunction

    task automatic chk1(input string name, input logic act, input logic req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%b required=%b", name, act, req);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic chk80(input string name, input logic [79:0] act, input logic [79:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic expect_wb(input logic [69:0] bus, input logic [9:0] addr);
        exp_t e;
        e.bus  = bus;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    // Monitor: every beat WB accepts must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (reset === 1'b0 && mif.ms_to_ws_valid === 1'b1 && mif.ws_allowin === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL wb_unexpected: actual=%h required=none", mif.ms_to_ws_bus);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk80("wb_beat", {mif.ms_to_ws_bus, mif.ms_to_ws_addr}, {e.bus, e.addr});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset              = 1'b1;
        stallM             = STALL_RUN;
        data_sram_rdata    = 32'd0;
        mif.es_to_ms_valid = 1'b0;
        mif.es_to_ms_bus   = 71'd0;
        mif.es_to_ms_addr  = 10'd0;
        mif.ws_allowin     = 1'b1;
        tick();
        tick();
        mid();
        chk1("rst_to_ws_valid", mif.ms_to_ws_valid, 1'b0);
        chk1("rst_allowin", mif.ms_allowin, 1'b1);
        chk1("rst_ms_valid", ms_valid_tohazard, 1'b0);
        tick();
        reset = 1'b0;

        // 1: ALU op passes straight through
        mif.es_to_ms_valid = 1'b1;
        mif.es_to_ms_bus   = mk_es(1'b0, 1'b1, 5'd3, 32'h0000_1234, 32'h0000_1000);
        mif.es_to_ms_addr  = 10'h0C3;
        expect_wb(mk_ws(1'b1, 5'd3, 32'h0000_1234, 32'h0000_1000), 10'h0C3);
        tick();
        mif.es_to_ms_valid = 1'b0;
        mid();
        chk1("t1_to_ws_valid", mif.ms_to_ws_valid, 1'b1);
        chk32("t1_forward", ms_forward_data, 32'h0000_1234);
        chk1("t1_gr_we_hz", ms_gr_we_tohazard, 1'b1);
        chk32("t1_dest_hz", 32'(ms_dest_tohazard), 32'd3);
        chk1("t1_load_hz", ms_load_tohazard, 1'b0);
        tick();

        // 2: load held across a 3-cycle WB stall while SRAM data changes
        mif.ws_allowin     = 1'b0;
        mif.es_to_ms_valid = 1'b1;
        mif.es_to_ms_bus   = mk_es(1'b1, 1'b1, 5'd5, 32'h0000_0200, 32'h0000_1004);
        mif.es_to_ms_addr  = 10'h0A5;
        expect_wb(mk_ws(1'b1, 5'd5, 32'hDEAD_BEEF, 32'h0000_1004), 10'h0A5);
        tick();
        mif.es_to_ms_valid = 1'b0;
        data_sram_rdata    = 32'hDEAD_BEEF;
        mid();
        chk1("t2_load_hz", ms_load_tohazard, 1'b1);
        chk32("t2_forward_live", ms_forward_data, 32'hDEAD_BEEF);
        tick();
        data_sram_rdata = 32'd0;
        mid();
        chk32("t2_forward_held", ms_forward_data, 32'hDEAD_BEEF);
        tick();
        tick();
        mif.ws_allowin = 1'b1;
        mid();
        tick();

        // 3: back-to-back loads, first one stalled for a cycle
        mif.ws_allowin     = 1'b0;
        mif.es_to_ms_valid = 1'b1;
        mif.es_to_ms_bus   = mk_es(1'b1, 1'b1, 5'd7, 32'h0000_0300, 32'h0000_2000);
        mif.es_to_ms_addr  = 10'h111;
        expect_wb(mk_ws(1'b1, 5'd7, 32'h0000_000A, 32'h0000_2000), 10'h111);
        tick();
        mif.es_to_ms_bus   = mk_es(1'b1, 1'b1, 5'd8, 32'h0000_0304, 32'h0000_2004);
        mif.es_to_ms_addr  = 10'h222;
        data_sram_rdata    = 32'h0000_000A;
        mid();
        chk1("t3_allowin_stalled", mif.ms_allowin, 1'b0);
        tick();
        data_sram_rdata = 32'h5555_5555;
        mif.ws_allowin  = 1'b1;
        expect_wb(mk_ws(1'b1, 5'd8, 32'h0000_000B, 32'h0000_2004), 10'h222);
        mid();
        chk1("t3_allowin_free", mif.ms_allowin, 1'b1);
        tick();
        mif.es_to_ms_valid = 1'b0;
        data_sram_rdata    = 32'h0000_000B;
        mid();
        tick();
        data_sram_rdata = 32'd0;

        // 4: flush drops the load in MEM and accepts the next EX instruction
        mif.ws_allowin     = 1'b0;
        mif.es_to_ms_valid = 1'b1;
        mif.es_to_ms_bus   = mk_es(1'b1, 1'b1, 5'd9, 32'h0000_0400, 32'h0000_3000);
        mif.es_to_ms_addr  = 10'h333;
        tick();
        data_sram_rdata    = 32'h0000_0077;
        stallM             = STALL_FLUSH;
        mif.es_to_ms_bus   = mk_es(1'b0, 1'b1, 5'd10, 32'h0000_0055, 32'h0000_3004);
        mif.es_to_ms_addr  = 10'h044;
        expect_wb(mk_ws(1'b1, 5'd10, 32'h0000_0055, 32'h0000_3004), 10'h044);
        mid();
        chk1("t4_flush_to_ws_valid", mif.ms_to_ws_valid, 1'b0);
        chk1("t4_flush_allowin", mif.ms_allowin, 1'b1);
        tick();
        stallM             = STALL_RUN;
        mif.es_to_ms_valid = 1'b0;
        mif.ws_allowin     = 1'b1;
        data_sram_rdata    = 32'd0;
        mid();
        chk1("t4_after_load_hz", ms_load_tohazard, 1'b0);
        tick();

        // 5: hold for two cycles (the second as the 2'b11 encoding)
        mif.es_to_ms_valid = 1'b1;
        mif.es_to_ms_bus   = mk_es(1'b0, 1'b1, 5'd11, 32'h0000_9999, 32'h0000_4000);
        mif.es_to_ms_addr  = 10'h155;
        expect_wb(mk_ws(1'b1, 5'd11, 32'h0000_9999, 32'h0000_4000), 10'h155);
        tick();
        stallM             = STALL_HOLD;
        mif.es_to_ms_bus   = mk_es(1'b0, 1'b1, 5'd12, 32'h0000_AAAA, 32'h0000_4004);
        mif.es_to_ms_addr  = 10'h2AA;
        mid();
        chk1("t5_hold_allowin", mif.ms_allowin, 1'b0);
        chk1("t5_hold_to_ws_valid", mif.ms_to_ws_valid, 1'b0);
        chk32("t5_hold_forward", ms_forward_data, 32'h0000_9999);
        chk32("t5_hold_addr", 32'(mif.ms_to_ws_addr), 32'h0000_0155);
        tick();
        stallM = 2'b11;
        mid();
        chk1("t5_both_allowin", mif.ms_allowin, 1'b0);
        chk1("t5_both_to_ws_valid", mif.ms_to_ws_valid, 1'b0);
        chk32("t5_both_forward", ms_forward_data, 32'h0000_9999);
        chk32("t5_both_dest_hz", 32'(ms_dest_tohazard), 32'd11);
        tick();
        stallM = STALL_RUN;
        expect_wb(mk_ws(1'b1, 5'd12, 32'h0000_AAAA, 32'h0000_4004), 10'h2AA);
        mid();
        chk1("t5_release_allowin", mif.ms_allowin, 1'b1);
        tick();
        mif.es_to_ms_valid = 1'b0;
        mid();
        tick();

        // 6: reset while a held load sits in MEM
        mif.ws_allowin     = 1'b0;
        mif.es_to_ms_valid = 1'b1;
        mif.es_to_ms_bus   = mk_es(1'b1, 1'b1, 5'd13, 32'h0000_0500, 32'h0000_5000);
        mif.es_to_ms_addr  = 10'h0FF;
        tick();
        mif.es_to_ms_valid = 1'b0;
        data_sram_rdata    = 32'hCAFE_F00D;
        tick();
        data_sram_rdata = 32'd0;
        reset           = 1'b1;
        tick();
        reset = 1'b0;
        mid();
        chk1("t6_ms_valid", ms_valid_tohazard, 1'b0);
        chk1("t6_to_ws_valid", mif.ms_to_ws_valid, 1'b0);
        chk1("t6_allowin", mif.ms_allowin, 1'b1);
`ifdef MEM_STAGE_PERF_EN
        chk32("t6_perf_load", perf_load_cnt, 32'd0);
        chk32("t6_perf_stall", perf_stall_cnt, 32'd0);
`endif
        mif.ws_allowin     = 1'b1;
        mif.es_to_ms_valid = 1'b1;
        mif.es_to_ms_bus   = mk_es(1'b0, 1'b1, 5'd14, 32'h0000_4321, 32'h0000_6000);
        mif.es_to_ms_addr  = 10'h01E;
        expect_wb(mk_ws(1'b1, 5'd14, 32'h0000_4321, 32'h0000_6000), 10'h01E);
        tick();
        mif.es_to_ms_bus   = mk_es(1'b1, 1'b1, 5'd15, 32'h0000_0600, 32'h0000_6004);
        mif.es_to_ms_addr  = 10'h02D;
        expect_wb(mk_ws(1'b1, 5'd15, 32'h0000_1111, 32'h0000_6004), 10'h02D);
        mid();
        chk32("t6_alu_forward", ms_forward_data, 32'h0000_4321);
        tick();
        mif.es_to_ms_valid = 1'b0;
        data_sram_rdata    = 32'h0000_1111;
        mid();
        tick();
        mid();

        chk32("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
